uart_transceiver: RTL and testbench

//   8N1 UART: independent transmitter and receiver sharing one clock and reset.
//   TX serialises a byte on trmt. RX deserialises the asynchronous RX line and flags rdy.

---
 rtl/uart_pkg.sv | 23 ++
 rtl/uart_bit_timer.sv | 40 ++++
 rtl/uart_transceiver.sv | 176 +++++++++++++++++
 tb/tb_uart_transceiver.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Brief    : Shared frame constants and FSM state types for the 8N1 UART.
// Revision : 1.0  initial release
// ============================================================================
package uart_pkg;

    localparam int FRAME_BITS = 10;
    localparam int DATA_BITS  = 8;

    typedef enum logic [0:0] {
        TX_IDLE     = 1'b0,
        TX_TRANSMIT = 1'b1
    } tx_state_t;

    typedef enum logic [0:0] {
        RX_IDLE    = 1'b0,
        RX_RECEIVE = 1'b1
    } rx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_bit_timer.sv
`default_nettype none
// ============================================================================
// Module   : uart_bit_timer
// Brief    : Free-running baud counter; tick marks the last clock of a bit.
// Revision : 1.0  initial release
// ============================================================================
module uart_bit_timer #(
    parameter int BAUD_DIV = 2604
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic load_half,
    output logic tick
);

    localparam int                 c_cnt_w = $clog2(BAUD_DIV);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(BAUD_DIV / 2);
    localparam logic [c_cnt_w-1:0] c_one   = c_cnt_w'(1);

    logic [c_cnt_w-1:0] r_cnt;

    // Half-period preload lets the receiver sample in the middle of each bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (load) begin
            r_cnt <= load_half ? c_half : '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_one;
        end
    end

    assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : uart_transceiver
// Brief    : 8N1 UART transmitter and receiver sharing one clock and reset.
// Revision : 1.0  initial release
// ============================================================================
module uart_transceiver
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 trmt,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 TX,
    output logic                 tx_done,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy
);

    localparam int              c_bit_w    = $clog2(FRAME_BITS);
    localparam logic [c_bit_w-1:0] c_last_bit = c_bit_w'(FRAME_BITS - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);

    // ---------------------------------------------------------------- TX ----
    tx_state_t               r_tx_state, w_tx_state_nxt;
    logic                    w_tx_accept, w_tx_shift, w_tx_finish, w_tx_tick;
    logic [FRAME_BITS-1:0]   r_tx_shreg;
    logic [c_bit_w-1:0]      r_tx_bit_cnt;
    logic                    r_tx_done;

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_tx_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_tx_accept),
        .load_half (1'b0),
        .tick      (w_tx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_tx_state <= TX_IDLE;
        else     r_tx_state <= w_tx_state_nxt;
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_accept    = 1'b0;
        w_tx_shift     = 1'b0;
        w_tx_finish    = 1'b0;
        case (r_tx_state)
            TX_IDLE: begin
                if (trmt) begin
                    w_tx_accept    = 1'b1;
                    w_tx_state_nxt = TX_TRANSMIT;
                end
            end
            TX_TRANSMIT: begin
                if (w_tx_tick) begin
                    w_tx_shift = 1'b1;
                    if (r_tx_bit_cnt == c_last_bit) begin
                        w_tx_finish    = 1'b1;
                        w_tx_state_nxt = TX_IDLE;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase
    end

    // The shift register bit 0 is the line itself; ones fill in behind the frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_shreg   <= '1;
            r_tx_bit_cnt <= '0;
            r_tx_done    <= 1'b0;
        end else if (w_tx_accept) begin
            r_tx_shreg   <= {1'b1, tx_data, 1'b0};
            r_tx_bit_cnt <= '0;
            r_tx_done    <= 1'b0;
        end else if (w_tx_shift) begin
            r_tx_shreg   <= {1'b1, r_tx_shreg[FRAME_BITS-1:1]};
            r_tx_bit_cnt <= r_tx_bit_cnt + c_bit_one;
            if (w_tx_finish) r_tx_done <= 1'b1;
        end
    end

    assign TX      = r_tx_shreg[0];
    assign tx_done = r_tx_done;

    // ---------------------------------------------------------------- RX ----
    rx_state_t               r_rx_state, w_rx_state_nxt;
    logic                    r_rx_meta, r_rx_sync;
    logic                    w_rx_start, w_rx_sample, w_rx_finish, w_rx_tick;
    logic [DATA_BITS-1:0]    r_rx_shreg;
    logic [c_bit_w-1:0]      r_rx_bit_cnt;
    logic [DATA_BITS-1:0]    r_rx_data;
    logic                    r_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
        end
    end

    uart_bit_timer #(.BAUD_DIV(BAUD_DIV)) u_rx_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (w_rx_start),
        .load_half (1'b1),
        .tick      (w_rx_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_rx_state <= RX_IDLE;
        else     r_rx_state <= w_rx_state_nxt;
    end

    always_comb begin
        w_rx_state_nxt = r_rx_state;
        w_rx_start     = 1'b0;
        w_rx_sample    = 1'b0;
        w_rx_finish    = 1'b0;
        case (r_rx_state)
            RX_IDLE: begin
                if (!r_rx_sync) begin
                    w_rx_start     = 1'b1;
                    w_rx_state_nxt = RX_RECEIVE;
                end
            end
            RX_RECEIVE: begin
                if (w_rx_tick) begin
                    w_rx_sample = 1'b1;
                    if (r_rx_bit_cnt == c_last_bit) begin
                        w_rx_finish    = 1'b1;
                        w_rx_state_nxt = RX_IDLE;
                    end
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    // The start sample drops off the bottom after eight more shifts; the stop
    // sample only closes the frame and is never stored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_shreg   <= '0;
            r_rx_bit_cnt <= '0;
            r_rx_data    <= '0;
        end else if (w_rx_start) begin
            r_rx_bit_cnt <= '0;
        end else if (w_rx_sample) begin
            r_rx_bit_cnt <= r_rx_bit_cnt + c_bit_one;
            if (w_rx_finish) r_rx_data  <= r_rx_shreg;
            else             r_rx_shreg <= {r_rx_sync, r_rx_shreg[DATA_BITS-1:1]};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_rdy <= 1'b0;
        else if (w_rx_finish)             r_rdy <= 1'b1;
        else if (w_rx_start || clr_rdy)   r_rdy <= 1'b0;
    end

    assign rx_data = r_rx_data;
    assign rdy     = r_rdy;

endmodule
`default_nettype wire

// File: tb/tb_uart_transceiver.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_transceiver
// Brief    : Loopback bench: sent bytes are queued and matched on each rdy rise.
// Revision : 1.0  initial release
// ============================================================================
module tb_uart_transceiver;

    localparam int B       = 100;
    localparam int TIMEOUT = 100000;

    logic       clk = 1'b0;
    logic       rst;
    logic       trmt;
    logic [7:0] tx_data;
    logic       TX;
    logic       tx_done;
    logic       RX;
    logic       clr_rdy;
    logic [7:0] rx_data;
    logic       rdy;

    int         n_checks = 0;
    int         n_pass   = 0;
    logic [7:0] exp_q[$];
    logic       prev_rdy = 1'b0;

    always #5 clk = ~clk;
    assign RX = TX;

    uart_transceiver #(.BAUD_DIV(B)) dut (
        .clk     (clk),
        .rst     (rst),
        .trmt    (trmt),
        .tx_data (tx_data),
        .TX      (TX),
        .tx_done (tx_done),
        .RX      (RX),
        .clr_rdy (clr_rdy),
        .rx_data (rx_data),
        .rdy     (rdy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Monitor: every rising rdy must deliver the oldest outstanding byte.
    always @(negedge clk) begin
        if (rdy === 1'b1 && prev_rdy === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL rx_unexpected: got byte %0h, expected no frame", rx_data);
            end else begin
                check("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
            end
        end
        prev_rdy = rdy;
    end

    task automatic send(input logic [7:0] b, input bit b2b, input bit inject, input bit hold_clr);
        logic [9:0] frame;
        int         k;
        bit         done;
        frame = {1'b1, b, 1'b0};
        if (!b2b) @(negedge clk);
        clr_rdy = hold_clr;
        trmt    = 1'b1;
        tx_data = b;
        exp_q.push_back(b);
        @(negedge clk);
        trmt    = 1'b0;
        tx_data = 8'($urandom);
        check("tx_start_bit", 32'(TX), 32'(0));
        check("tx_done_clear", 32'(tx_done), 32'(0));
        k    = 0;
        done = 1'b0;
        while (!done && k < TIMEOUT) begin
            @(negedge clk);
            k++;
            trmt = 1'b0;
            if (inject && k == 2 * B) begin
                trmt    = 1'b1;
                tx_data = ~b;
            end
            if ((k % B) == B / 2 && (k / B) < 10)
                check("tx_bit", 32'(TX), 32'(frame[k / B]));
            if (tx_done === 1'b1) done = 1'b1;
        end
        check("tx_done_timeout", 32'(done), 32'(1));
        if (done) begin
            check("frame_len", 32'(k), 32'(10 * B));
            check("tx_idle_high", 32'(TX), 32'(1));
            if (hold_clr) check("rdy_held_clr", 32'(rdy), 32'(0));
            else          check("rdy_before_tx_done", 32'(rdy), 32'(1));
        end
        clr_rdy = 1'b0;
    endtask

    initial begin
        rst     = 1'b1;
        trmt    = 1'b0;
        clr_rdy = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        check("reset_tx", 32'(TX), 32'(1));
        check("reset_tx_done", 32'(tx_done), 32'(0));
        check("reset_rdy", 32'(rdy), 32'(0));
        check("reset_rx_data", 32'(rx_data), 32'(0));
        rst = 1'b0;

        send(8'hAA, 1'b0, 1'b0, 1'b0);
        check("rx_data_aa", 32'(rx_data), 32'(8'hAA));

        @(negedge clk);
        clr_rdy = 1'b1;
        repeat (2) @(negedge clk);
        check("clr_rdy_low", 32'(rdy), 32'(0));
        clr_rdy = 1'b0;
        repeat (5) @(negedge clk);
        check("rdy_stays_low", 32'(rdy), 32'(0));
        check("tx_done_held", 32'(tx_done), 32'(1));

        send(8'h78, 1'b0, 1'b0, 1'b0);
        check("rx_data_78", 32'(rx_data), 32'(8'h78));

        // Abort a frame part way through; nothing is queued for it.
        @(negedge clk);
        trmt    = 1'b1;
        tx_data = 8'h33;
        @(negedge clk);
        trmt = 1'b0;
        repeat (3 * B) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midreset_tx", 32'(TX), 32'(1));
        check("midreset_tx_done", 32'(tx_done), 32'(0));
        check("midreset_rdy", 32'(rdy), 32'(0));
        check("midreset_rx_data", 32'(rx_data), 32'(0));
        repeat (3) @(negedge clk);
        rst = 1'b0;

        send(8'h55, 1'b0, 1'b0, 1'b0);
        check("rx_data_55", 32'(rx_data), 32'(8'h55));

        send(8'hC3, 1'b0, 1'b1, 1'b0);
        check("rx_data_c3", 32'(rx_data), 32'(8'hC3));

        for (int i = 0; i < 8; i++) begin
            send(8'($urandom), (i > 0) ? 1'($urandom_range(0, 1)) : 1'b0,
                 1'b0, (i == 3));
        end

        repeat (2 * B) @(negedge clk);
        check("scoreboard_drain", 32'(exp_q.size()), 32'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
